// File: rtl/dma_mem_if.sv
// dma_mem_if: DMA-side read/write bus between a DMA engine (master) and the memory responder (slave).
interface dma_mem_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) ();
  logic                  mem_r_ready;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic                  mem_r_ack;
  logic                  mem_r_valid;
  logic [DATA_WIDTH-1:0] mem_r_data;
  logic                  mem_w_valid;
  logic [ADDR_WIDTH-1:0] mem_w_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [3:0]            rd_outstanding;
  logic                  oob_err;
  modport master (
    output mem_r_ready, mem_r_addr, mem_w_valid, mem_w_addr, mem_w_data,
    input  mem_r_ack, mem_r_valid, mem_r_data, rd_outstanding, oob_err
  );
  modport slave (
    input  mem_r_ready, mem_r_addr, mem_w_valid, mem_w_addr, mem_w_data,
    output mem_r_ack, mem_r_valid, mem_r_data, rd_outstanding, oob_err
  );
endinterface

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: pipelined word memory answering DMA reads after RD_LAT cycles and absorbing writes.
// Define DMA_MEM_DUAL_PORT_EN for a true dual-port array; otherwise a write blocks a same-cycle read.
module dma_mem_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int RD_LAT     = 2
) (
  input logic      wb_clk_i,
  input logic      wb_rst_i,
  dma_mem_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [RD_LAT-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LAT];
  logic [3:0]            cnt_q, cnt_d;
  logic                  oob_q, oob_d;
  logic                  r_oob, w_oob, accept, ret;
  logic [DATA_WIDTH-1:0] rd_word;
`ifdef DMA_MEM_DUAL_PORT_EN
  assign accept = bus.mem_r_ready & ~wb_rst_i;
`else
  assign accept = bus.mem_r_ready & ~bus.mem_w_valid & ~wb_rst_i;
`endif
  always_comb begin
    r_oob   = |bus.mem_r_addr[ADDR_WIDTH-1:MEM_AW];
    w_oob   = |bus.mem_w_addr[ADDR_WIDTH-1:MEM_AW];
    rd_word = r_oob ? '0 : mem_q[bus.mem_r_addr[MEM_AW-1:0]];
    ret     = vld_q[RD_LAT-1];
    cnt_d   = cnt_q + 4'(accept) - 4'(ret);
    oob_d   = oob_q | (accept & r_oob) | (bus.mem_w_valid & w_oob);
  end
  // The array is sampled at the accept edge, so a same-edge write is not yet visible.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vld_q <= '0;
      cnt_q <= '0;
      oob_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      dat_q[0] <= accept ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      cnt_q <= cnt_d;
      oob_q <= oob_d;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (bus.mem_w_valid && !w_oob) mem_q[bus.mem_w_addr[MEM_AW-1:0]] <= bus.mem_w_data;
  end
  assign bus.mem_r_ack      = accept;
  assign bus.mem_r_valid    = vld_q[RD_LAT-1];
  assign bus.mem_r_data     = dat_q[RD_LAT-1];
  assign bus.rd_outstanding = cnt_q;
  assign bus.oob_err        = oob_q;
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: per-cycle vector table plus directed reset and dual-port sequences.
module tb_dma_mem_responder;
  typedef struct {
    logic        rr;
    logic [12:0] ra;
    logic        wv;
    logic [12:0] wa;
    logic [31:0] wd;
    logic        ack;
    logic        val;
    logic [31:0] data;
    logic [3:0]  out;
    logic        oob;
  } vec_t;
  localparam int N = 34;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tv [N];
  dma_mem_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus ();
  dma_mem_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .MEM_AW(10), .RD_LAT(2)) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  function automatic logic [31:0] wdat(input int i);
    return (i == 5) ? 32'hA5A5_0001 : 32'h0000_1000 + 32'(i);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rr, input logic [12:0] ra, input logic wv, input logic [12:0] wa, input logic [31:0] wd);
    bus.mem_r_ready = rr;
    bus.mem_r_addr  = ra;
    bus.mem_w_valid = wv;
    bus.mem_w_addr  = wa;
    bus.mem_w_data  = wd;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    for (int t = 0; t < N; t++) tv[t] = '{default: '0};
    for (int i = 0; i < 8; i++) begin
      tv[i].wv = 1; tv[i].wa = 13'(i); tv[i].wd = wdat(i);
      tv[8+i].rr = 1; tv[8+i].ra = 13'(i); tv[8+i].ack = 1;
      tv[10+i].val = 1; tv[10+i].data = wdat(i);
    end
    tv[9].out = 1;
    for (int t = 10; t <= 16; t++) tv[t].out = 2;
    tv[17].out = 1;
    for (int t = 19; t <= 22; t++) begin
      tv[t].rr = 1; tv[t].ra = 13'd2;
    end
    for (int t = 19; t <= 21; t++) begin
      tv[t].wv = 1; tv[t].wa = 13'd2; tv[t].wd = 32'h22;
    end
`ifdef DMA_MEM_DUAL_PORT_EN
    for (int t = 19; t <= 22; t++) tv[t].ack = 1;
    tv[20].out = 1; tv[21].out = 2; tv[22].out = 2; tv[23].out = 2; tv[24].out = 1;
    tv[21].val = 1; tv[21].data = 32'h1002;
    for (int t = 22; t <= 24; t++) begin
      tv[t].val = 1; tv[t].data = 32'h22;
    end
`else
    tv[22].ack = 1;
    tv[23].out = 1; tv[24].out = 1;
    tv[24].val = 1; tv[24].data = 32'h22;
`endif
    tv[26].rr = 1; tv[26].ra = 13'd1024; tv[26].ack = 1;
    tv[27].out = 1;
    tv[28].val = 1; tv[28].out = 1;
    tv[29].wv = 1; tv[29].wa = 13'd1024; tv[29].wd = 32'hDEAD_BEEF;
    tv[30].rr = 1; tv[30].ack = 1;
    tv[31].out = 1;
    tv[32].val = 1; tv[32].data = 32'h1000; tv[32].out = 1;
    for (int t = 27; t < N; t++) tv[t].oob = 1;
    drive(1, 13'd5, 0, 0, 0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    #1;
    chk("reset ack", 32'(bus.mem_r_ack), 0);
    chk("reset valid", 32'(bus.mem_r_valid), 0);
    chk("reset data", bus.mem_r_data, 0);
    chk("reset outstanding", 32'(bus.rd_outstanding), 0);
    chk("reset oob", 32'(bus.oob_err), 0);
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    drive(0, 0, 0, 0, 0);
    for (int t = 0; t < N; t++) begin
      @(negedge wb_clk_i);
      drive(tv[t].rr, tv[t].ra, tv[t].wv, tv[t].wa, tv[t].wd);
      #1;
      chk($sformatf("row%0d ack", t), 32'(bus.mem_r_ack), 32'(tv[t].ack));
      chk($sformatf("row%0d valid", t), 32'(bus.mem_r_valid), 32'(tv[t].val));
      chk($sformatf("row%0d data", t), bus.mem_r_data, tv[t].data);
      chk($sformatf("row%0d outstanding", t), 32'(bus.rd_outstanding), 32'(tv[t].out));
      chk($sformatf("row%0d oob", t), 32'(bus.oob_err), 32'(tv[t].oob));
    end
    @(negedge wb_clk_i);
    drive(1, 13'd5, 0, 0, 0);
    #1 chk("inflight ack0", 32'(bus.mem_r_ack), 1);
    @(negedge wb_clk_i);
    drive(1, 13'd6, 0, 0, 0);
    #1 chk("inflight ack1", 32'(bus.mem_r_ack), 1);
    @(posedge wb_clk_i);
    wb_rst_i = 1;
    #1;
    chk("rst valid", 32'(bus.mem_r_valid), 0);
    chk("rst outstanding", 32'(bus.rd_outstanding), 0);
    chk("rst oob cleared", 32'(bus.oob_err), 0);
    @(negedge wb_clk_i);
    #1 chk("rst ack blocked", 32'(bus.mem_r_ack), 0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      #1;
      chk($sformatf("post-rst valid c%0d", i), 32'(bus.mem_r_valid), 0);
      chk($sformatf("post-rst outstanding c%0d", i), 32'(bus.rd_outstanding), 0);
    end
    @(negedge wb_clk_i);
    drive(1, 13'd5, 0, 0, 0);
    #1 chk("reread ack", 32'(bus.mem_r_ack), 1);
    @(negedge wb_clk_i);
    drive(0, 0, 0, 0, 0);
    @(negedge wb_clk_i);
    #1;
    chk("reread valid", 32'(bus.mem_r_valid), 1);
    chk("reread data", bus.mem_r_data, 32'hA5A5_0001);
`ifdef DMA_MEM_DUAL_PORT_EN
    @(negedge wb_clk_i);
    drive(0, 0, 1, 13'd3, 32'h1);
    @(negedge wb_clk_i);
    drive(1, 13'd3, 1, 13'd3, 32'h2);
    #1 chk("dp same-cycle ack", 32'(bus.mem_r_ack), 1);
    @(negedge wb_clk_i);
    drive(1, 13'd3, 0, 0, 0);
    #1 chk("dp next ack", 32'(bus.mem_r_ack), 1);
    @(negedge wb_clk_i);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("dp old valid", 32'(bus.mem_r_valid), 1);
    chk("dp old data", bus.mem_r_data, 32'h1);
    @(negedge wb_clk_i);
    #1;
    chk("dp new valid", 32'(bus.mem_r_valid), 1);
    chk("dp new data", bus.mem_r_data, 32'h2);
`endif
    @(negedge wb_clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
